// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding, load-use/scoreboard hazard detection,
// hazard FSM and saturating stall counter for the 5-stage pipeline.
module hazard_forward_unit #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] if_id_rs,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_memread,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      mem_wb_regwrite,
  input  logic                      sb_issue,
  input  logic [REG_AW-1:0]         sb_issue_rd,
  input  logic                      sb_done,
  input  logic [REG_AW-1:0]         sb_done_rd,
  input  logic                      stall_cnt_clr,
  output logic [NUM_SRC*2-1:0]      forward_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic [NUM_REGS-1:0]       sb_pending,
  output logic [1:0]                hazard_state,
  output logic [CNT_W-1:0]          stall_cnt
);
  typedef enum logic [1:0] {IDLE = 2'b00, LU_STALL = 2'b01, SB_WAIT = 2'b10} state_t;
  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lu, sbh;
  always_comb begin
    lu          = 1'b0;
    sbh         = 1'b0;
    forward_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lu  |= id_ex_memread && id_ex_rd != '0 && if_id_rs[i*REG_AW +: REG_AW] == id_ex_rd;
      sbh |= if_id_rs[i*REG_AW +: REG_AW] != '0 && sb_q[if_id_rs[i*REG_AW +: REG_AW]];
      forward_sel[i*2 +: 2] =
        (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == id_ex_rs[i*REG_AW +: REG_AW]) ? 2'b10 :
        (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == id_ex_rs[i*REG_AW +: REG_AW]) ? 2'b01 :
        2'b00;
    end
  end
  assign stall  = lu | sbh;
  assign bubble = stall;
  // Issue is applied after done so a same-cycle set/clear of one register leaves it set.
  always_comb begin
    sb_d = sb_q;
    if (sb_done) sb_d[sb_done_rd] = 1'b0;
    if (sb_issue && sb_issue_rd != '0) sb_d[sb_issue_rd] = 1'b1;
  end
  // IDLE and SB_WAIT share transitions; LU_STALL never re-enters itself.
  always_comb begin
    state_d = sbh ? SB_WAIT : (lu && state_q != LU_STALL) ? LU_STALL : IDLE;
    cnt_d   = stall_cnt_clr ? '0 : (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end
  assign sb_pending   = sb_q;
  assign hazard_state = state_q;
  assign stall_cnt    = cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard-driven checks of forwarding, hazards, FSM and stall counter.
module tb_hazard_forward_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [9:0]  if_id_rs, id_ex_rs;
  logic [4:0]  id_ex_rd, ex_mem_rd, mem_wb_rd, sb_issue_rd, sb_done_rd;
  logic        id_ex_memread, ex_mem_regwrite, mem_wb_regwrite, sb_issue, sb_done, stall_cnt_clr;
  logic [3:0]  forward_sel, fs4;
  logic        stall, bubble, st4, bb4;
  logic [31:0] sb_pending, sp4;
  logic [1:0]  hazard_state, hs4;
  logic [15:0] stall_cnt;
  logic [3:0]  cnt4;
  int          tests = 0, fails = 0;
  logic [63:0] q[$];
  logic [63:0] exp;

  always #5 clk = ~clk;

  hazard_forward_unit u_dut (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .sb_issue(sb_issue),
    .sb_issue_rd(sb_issue_rd), .sb_done(sb_done), .sb_done_rd(sb_done_rd),
    .stall_cnt_clr(stall_cnt_clr), .forward_sel(forward_sel), .stall(stall), .bubble(bubble),
    .sb_pending(sb_pending), .hazard_state(hazard_state), .stall_cnt(stall_cnt)
  );

  hazard_forward_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .if_id_rs(if_id_rs), .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .sb_issue(sb_issue),
    .sb_issue_rd(sb_issue_rd), .sb_done(sb_done), .sb_done_rd(sb_done_rd),
    .stall_cnt_clr(stall_cnt_clr), .forward_sel(fs4), .stall(st4), .bubble(bb4),
    .sb_pending(sp4), .hazard_state(hs4), .stall_cnt(cnt4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    if_id_rs = '0; id_ex_rs = '0; id_ex_rd = '0; ex_mem_rd = '0; mem_wb_rd = '0;
    sb_issue_rd = '0; sb_done_rd = '0; id_ex_memread = 0; ex_mem_regwrite = 0;
    mem_wb_regwrite = 0; sb_issue = 0; sb_done = 0; stall_cnt_clr = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    id_ex_memread = 1; id_ex_rd = 5'd7; if_id_rs = {5'd7, 5'd0};
    #2;
    q.push_back({32'd0, 2'b00, 16'd0, 1'b1, 1'b1});
    exp = q.pop_front(); tests++;
    if ({sb_pending, hazard_state, stall_cnt, stall, bubble} !== exp[51:0]) begin
      fails++; $display("FAIL reset_state got %h want %h", {sb_pending, hazard_state, stall_cnt, stall, bubble}, exp[51:0]);
    end
    tick(); tick();
    q.push_back({2'b00, 16'd0});
    exp = q.pop_front(); tests++;
    if ({hazard_state, stall_cnt} !== exp[17:0]) begin
      fails++; $display("FAIL reset_hold got %h want %h", {hazard_state, stall_cnt}, exp[17:0]);
    end
    clear_inputs();
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_forward;
    logic [3:0] m;
    clear_inputs();
    ex_mem_rd = 5; ex_mem_regwrite = 1; mem_wb_rd = 5; mem_wb_regwrite = 1; id_ex_rs = {5'd0, 5'd5};
    q.push_back(64'b0010);
    #1; exp = q.pop_front(); tests++;
    if (forward_sel !== exp[3:0]) begin fails++; $display("FAIL fwd_exmem_wins got %b want %b", forward_sel, exp[3:0]); end
    ex_mem_regwrite = 0;
    q.push_back(64'b0001);
    #1; exp = q.pop_front(); tests++;
    if (forward_sel !== exp[3:0]) begin fails++; $display("FAIL fwd_memwb got %b want %b", forward_sel, exp[3:0]); end
    ex_mem_rd = 0; mem_wb_rd = 0; ex_mem_regwrite = 1; mem_wb_regwrite = 1; id_ex_rs = '0;
    q.push_back(64'b0000);
    #1; exp = q.pop_front(); tests++;
    if (forward_sel !== exp[3:0]) begin fails++; $display("FAIL fwd_rd0 got %b want %b", forward_sel, exp[3:0]); end
    for (int n = 0; n < 24; n++) begin
      ex_mem_rd = 5'($urandom_range(0, 4)); mem_wb_rd = 5'($urandom_range(0, 4));
      ex_mem_regwrite = 1'($urandom_range(0, 1)); mem_wb_regwrite = 1'($urandom_range(0, 1));
      id_ex_rs = {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))};
      for (int s = 0; s < 2; s++) begin
        if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == id_ex_rs[s*5 +: 5]) m[s*2 +: 2] = 2'b10;
        else if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == id_ex_rs[s*5 +: 5]) m[s*2 +: 2] = 2'b01;
        else m[s*2 +: 2] = 2'b00;
      end
      q.push_back({60'd0, m});
      #1; exp = q.pop_front(); tests++;
      if (forward_sel !== exp[3:0]) begin fails++; $display("FAIL fwd_rand%0d got %b want %b", n, forward_sel, exp[3:0]); end
    end
    clear_inputs();
  endtask

  task automatic test_load_use;
    clear_inputs();
    @(negedge clk);
    id_ex_memread = 1; id_ex_rd = 5'd7; if_id_rs = {5'd7, 5'd0};
    q.push_back(64'b11);
    #1; exp = q.pop_front(); tests++;
    if ({stall, bubble} !== exp[1:0]) begin fails++; $display("FAIL lu_stall got %b want %b", {stall, bubble}, exp[1:0]); end
    tick();
    id_ex_memread = 0;
    q.push_back(64'b01);
    exp = q.pop_front(); tests++;
    if (hazard_state !== exp[1:0]) begin fails++; $display("FAIL lu_state got %b want %b", hazard_state, exp[1:0]); end
    tick();
    q.push_back({2'b00, 1'b0});
    exp = q.pop_front(); tests++;
    if ({hazard_state, stall} !== exp[2:0]) begin fails++; $display("FAIL lu_idle got %b want %b", {hazard_state, stall}, exp[2:0]); end
    clear_inputs();
  endtask

  task automatic test_scoreboard;
    clear_inputs();
    stall_cnt_clr = 1; tick(); stall_cnt_clr = 0;
    if_id_rs = {5'd0, 5'd9}; sb_issue = 1; sb_issue_rd = 9;
    tick();
    sb_issue = 0;
    q.push_back({32'h200, 1'b1, 2'b00});
    exp = q.pop_front(); tests++;
    if ({sb_pending, stall, hazard_state} !== exp[34:0]) begin
      fails++; $display("FAIL sb_set got %h want %h", {sb_pending, stall, hazard_state}, exp[34:0]);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      q.push_back({1'b1, 2'b10});
      exp = q.pop_front(); tests++;
      if ({stall, hazard_state} !== exp[2:0]) begin
        fails++; $display("FAIL sb_wait%0d got %b want %b", k, {stall, hazard_state}, exp[2:0]);
      end
    end
    sb_done = 1; sb_done_rd = 9;
    tick();
    sb_done = 0;
    q.push_back({32'd0, 1'b0, 16'd11, 4'd11});
    exp = q.pop_front(); tests++;
    if ({sb_pending, stall, stall_cnt, cnt4} !== exp[52:0]) begin
      fails++; $display("FAIL sb_release got %h want %h", {sb_pending, stall, stall_cnt, cnt4}, exp[52:0]);
    end
    tick();
    q.push_back({2'b00, 16'd11});
    exp = q.pop_front(); tests++;
    if ({hazard_state, stall_cnt} !== exp[17:0]) begin
      fails++; $display("FAIL sb_idle got %h want %h", {hazard_state, stall_cnt}, exp[17:0]);
    end
    clear_inputs();
  endtask

  task automatic test_same_cycle;
    clear_inputs();
    sb_issue = 1; sb_issue_rd = 3; sb_done = 1; sb_done_rd = 3;
    tick();
    q.push_back(64'h8);
    exp = q.pop_front(); tests++;
    if (sb_pending !== exp[31:0]) begin fails++; $display("FAIL sb_set_wins got %h want %h", sb_pending, exp[31:0]); end
    sb_issue_rd = 0; sb_done_rd = 4;
    tick();
    q.push_back(64'h8);
    exp = q.pop_front(); tests++;
    if (sb_pending !== exp[31:0]) begin fails++; $display("FAIL sb_x0_noop got %h want %h", sb_pending, exp[31:0]); end
    sb_issue = 0; sb_done_rd = 3;
    tick();
    q.push_back(64'h0);
    exp = q.pop_front(); tests++;
    if (sb_pending !== exp[31:0]) begin fails++; $display("FAIL sb_clear got %h want %h", sb_pending, exp[31:0]); end
    clear_inputs();
  endtask

  task automatic test_saturate;
    clear_inputs();
    stall_cnt_clr = 1; tick(); stall_cnt_clr = 0;
    id_ex_memread = 1; id_ex_rd = 5'd7; if_id_rs = {5'd7, 5'd0};
    repeat (20) tick();
    q.push_back({16'd20, 4'd15});
    exp = q.pop_front(); tests++;
    if ({stall_cnt, cnt4} !== exp[19:0]) begin fails++; $display("FAIL cnt_sat got %h want %h", {stall_cnt, cnt4}, exp[19:0]); end
    stall_cnt_clr = 1;
    tick();
    stall_cnt_clr = 0;
    q.push_back({16'd0, 4'd0});
    exp = q.pop_front(); tests++;
    if ({stall_cnt, cnt4} !== exp[19:0]) begin fails++; $display("FAIL cnt_clr got %h want %h", {stall_cnt, cnt4}, exp[19:0]); end
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    sb_issue = 1; sb_issue_rd = 12; tick();
    sb_issue_rd = 20; tick();
    sb_issue = 0; if_id_rs = {5'd0, 5'd12};
    tick(); tick();
    q.push_back({32'h0010_1000, 2'b10});
    exp = q.pop_front(); tests++;
    if ({sb_pending, hazard_state} !== exp[33:0]) begin
      fails++; $display("FAIL mid_pending got %h want %h", {sb_pending, hazard_state}, exp[33:0]);
    end
    #2 rst_n = 0;
    #1;
    q.push_back({32'd0, 2'b00, 1'b0});
    exp = q.pop_front(); tests++;
    if ({sb_pending, hazard_state, stall} !== exp[34:0]) begin
      fails++; $display("FAIL mid_reset got %h want %h", {sb_pending, hazard_state, stall}, exp[34:0]);
    end
    @(negedge clk) rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_same_cycle();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
